// File: rtl/sdfm_pkg.sv
// SDFM shared constants and OSR clamping helper.
// Used by the demodulator channels and the SDFM register block.
package sdfm_pkg;

   localparam int OSR_MAX = 256;
   localparam int OSR_MIN = 4;
   localparam int OSR_W   = 9;
   localparam int ACC_W   = 25;

   // Map any 9-bit request onto the legal 4..256 decimation range
   function automatic logic [OSR_W-1:0] clamp_osr(input logic [OSR_W-1:0] v);
      if (v == '0 || v > OSR_W'(OSR_MAX))
         return OSR_W'(OSR_MAX);
      if (v < OSR_W'(OSR_MIN))
         return OSR_W'(OSR_MIN);
      return v;
   endfunction

endpackage

// File: rtl/sdfm_sdclk_sync.sv
// SDCLK/DSDIN synchroniser: two flops each, plus a third SDCLK flop
// for rising-edge detection. stb marks one cycle per SDCLK rise.
module sdfm_sdclk_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic sdclk,
   input  logic dsdin,
   output logic stb,
   output logic x
);

   logic sclk_s1;
   logic sclk_s2;
   logic sclk_s3;
   logic din_s1;
   logic din_s2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_s1 <= 1'b0;
         sclk_s2 <= 1'b0;
         sclk_s3 <= 1'b0;
         din_s1  <= 1'b0;
         din_s2  <= 1'b0;
      end else begin
         sclk_s1 <= sdclk;
         sclk_s2 <= sclk_s1;
         sclk_s3 <= sclk_s2;
         din_s1  <= dsdin;
         din_s2  <= din_s1;
      end
   end

   assign stb = sclk_s2 & ~sclk_s3;
   assign x   = din_s2;

endmodule

// File: rtl/sdfm_sinc3_channel.sv
// One SDFM demodulator channel: sinc3 CIC decimator with settle
// blanking and a DRDY/ACK/OVR handshake towards the register block.
module sdfm_sinc3_channel
   import sdfm_pkg::*;
(
   input  logic             EXTCLK,
   input  logic             EXTRSTn,
   input  logic             EN,
   input  logic [OSR_W-1:0] OSR,
   input  logic             SDCLK,
   input  logic             DSDIN,
   input  logic             ACK,
   output logic [ACC_W-1:0] DATA,
   output logic             DRDY,
   output logic             OVR
);

   logic             stb;
   logic             x;
   logic             en_q;
   logic [OSR_W-1:0] osr_act;
   logic [OSR_W-1:0] cnt;
   logic [ACC_W-1:0] i1;
   logic [ACC_W-1:0] i2;
   logic [ACC_W-1:0] i3;
   logic [ACC_W-1:0] i3z;
   logic [ACC_W-1:0] c1z;
   logic [ACC_W-1:0] c2z;
   logic [ACC_W-1:0] c1;
   logic [ACC_W-1:0] c2;
   logic [ACC_W-1:0] c3;
   logic [ACC_W-1:0] samp;
   logic [1:0]       settle;
   logic             fire;
   logic             samp_v;

   sdfm_sdclk_sync u_sync (
      .clk   (EXTCLK),
      .rst_n (EXTRSTn),
      .sdclk (SDCLK),
      .dsdin (DSDIN),
      .stb   (stb),
      .x     (x)
   );

   assign c1 = i3 - i3z;
   assign c2 = c1 - c1z;
   assign c3 = c2 - c2z;

   always_ff @(posedge EXTCLK) begin
      if (!EXTRSTn) begin
         en_q    <= 1'b0;
         osr_act <= OSR_W'(OSR_MAX);
      end else begin
         en_q <= EN;
         if (EN && !en_q)
            osr_act <= clamp_osr(OSR);
      end
   end

   // Filter state is forced to zero whenever the channel is disabled
   always_ff @(posedge EXTCLK) begin
      if (!EXTRSTn || !EN) begin
         i1     <= '0;
         i2     <= '0;
         i3     <= '0;
         i3z    <= '0;
         c1z    <= '0;
         c2z    <= '0;
         cnt    <= '0;
         settle <= '0;
         fire   <= 1'b0;
         samp_v <= 1'b0;
         samp   <= '0;
      end else begin
         fire   <= 1'b0;
         samp_v <= 1'b0;
         if (stb) begin
            i1 <= i1 + {{(ACC_W-1){1'b0}}, x};
            i2 <= i2 + i1;
            i3 <= i3 + i2;
            if (cnt == osr_act - OSR_W'(1)) begin
               cnt  <= '0;
               fire <= 1'b1;
            end else begin
               cnt <= cnt + OSR_W'(1);
            end
         end
         if (fire) begin
            i3z <= i3;
            c1z <= c1;
            c2z <= c2;
            if (settle == 2'd3) begin
               samp_v <= 1'b1;
               samp   <= c3;
            end else begin
               settle <= settle + 2'd1;
            end
         end
      end
   end

   // A load coinciding with ACK keeps DRDY set but never flags overrun
   always_ff @(posedge EXTCLK) begin
      if (!EXTRSTn) begin
         DATA <= '0;
         DRDY <= 1'b0;
         OVR  <= 1'b0;
      end else if (samp_v) begin
         DATA <= samp;
         DRDY <= 1'b1;
         if (ACK)
            OVR <= 1'b0;
         else if (DRDY)
            OVR <= 1'b1;
      end else if (ACK) begin
         DRDY <= 1'b0;
         OVR  <= 1'b0;
      end
   end

endmodule
